// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO for the MIPS core.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU are no-ops.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

    stateT              state, nextState;
    logic [CW-1:0]      iterCnt;
    logic [WIDTH-1:0]   opA, opB, hiReg, loReg;
    logic [2*WIDTH-1:0] acc, prodFix;
    logic [WIDTH:0]     mulSum;
    logic               negRes, doneReg, launch, iterOp;
    logic               signedOp, aNeg, bNeg, lastIter;

    assign signedOp = ~op[0];
    assign aNeg     = signedOp & a[WIDTH-1];
    assign bNeg     = signedOp & b[WIDTH-1];
    assign lastIter = (iterCnt == CW'(WIDTH-1));
`ifdef MDU_DIV_EN
    assign iterOp   = ~op[2];
`else
    assign iterOp   = (op[2:1] == 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        launch    = 1'b0;
        case (state)
            IDLE: if (start && iterOp) begin
                nextState = CALC;
                launch    = 1'b1;
            end
            CALC: if (lastIter) nextState = FIX;
            FIX:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Shift-add: add the multiplicand into the upper half, then shift the whole product right.
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opB[0] ? opA : '0)};
    assign prodFix = negRes ? -acc : acc;

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] remReg, remFix, quoFix;
    logic [WIDTH:0]   remShift, remDiff;
    logic             negRem, divOp, bZero, divZeroReg;

    // Dividend bits enter the remainder from opA's MSB; quotient bits fill opA from the LSB.
    assign remShift = {remReg, opA[WIDTH-1]};
    assign remDiff  = remShift - {1'b0, opB};
    assign quoFix   = negRes ? -opA : opA;
    // A zero divisor leaves |a| in the remainder, so sign-fixing restores the original a.
    assign remFix   = negRem ? -remReg : remReg;
    assign div_zero = divZeroReg;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            acc        <= '0;
            opA        <= '0;
            opB        <= '0;
            iterCnt    <= '0;
            negRes     <= 1'b0;
`ifdef MDU_DIV_EN
            remReg     <= '0;
            negRem     <= 1'b0;
            divOp      <= 1'b0;
            bZero      <= 1'b0;
            divZeroReg <= 1'b0;
`endif
        end else begin
            doneReg    <= 1'b0;
`ifdef MDU_DIV_EN
            divZeroReg <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    if (launch) begin
                        opA     <= aNeg ? -a : a;
                        opB     <= bNeg ? -b : b;
                        negRes  <= aNeg ^ bNeg;
                        acc     <= '0;
                        iterCnt <= '0;
`ifdef MDU_DIV_EN
                        negRem  <= aNeg;
                        divOp   <= op[1];
                        bZero   <= (b == '0);
                        remReg  <= '0;
`endif
                    end else if (op == OP_MTHI) begin
                        hiReg   <= a;
                        doneReg <= 1'b1;
                    end else if (op == OP_MTLO) begin
                        loReg   <= a;
                        doneReg <= 1'b1;
                    end
                end
                CALC: begin
                    iterCnt <= iterCnt + 1'b1;
`ifdef MDU_DIV_EN
                    if (divOp) begin
                        if (!remDiff[WIDTH]) begin
                            remReg <= remDiff[WIDTH-1:0];
                            opA    <= {opA[WIDTH-2:0], 1'b1};
                        end else begin
                            remReg <= remShift[WIDTH-1:0];
                            opA    <= {opA[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        acc <= {mulSum, acc[WIDTH-1:1]};
                        opB <= opB >> 1;
                    end
                end
                FIX: begin
                    doneReg <= 1'b1;
`ifdef MDU_DIV_EN
                    if (divOp) begin
                        hiReg      <= remFix;
                        loReg      <= bZero ? '1 : quoFix;
                        divZeroReg <= bZero;
                    end else
`endif
                    begin
                        hiReg <= prodFix[2*WIDTH-1:WIDTH];
                        loReg <= prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit; divide checks follow the MDU_DIV_EN build option.
module tb_mult_div_unit;

    logic        clk, rst, start;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          c0;
    } expT;

    expT         sb[$];
    expT         me;
    int          nTests = 0, nFail = 0, cyc = 0;
    logic [31:0] curHi = '0, curLo = '0, rA, rB;
    logic [2:0]  rOp;
    logic [64:0] m;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        if (o[1] && y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o[1]) begin
            if (o[0]) begin q = ux / uy; r = ux % uy; end
            else      begin q = sx / sy; r = sx % sy; end
            return {1'b0, r[31:0], q[31:0]};
        end
        p = o[0] ? ux * uy : sx * sy;
        return {1'b0, p[63:0]};
    endfunction

    // Called at a negedge; start stays high until the caller drops it.
    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit pushIt,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz, input string tag);
        expT e;
        start = 1'b1; op = o; a = x; b = y;
        if (pushIt) begin
            e.tag = tag; e.hi = eh; e.lo = el; e.dz = edz;
            e.lat = o[2] ? 0 : 33;
            e.c0  = cyc + 1;
            sb.push_back(e);
            curHi = eh; curLo = el;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) chk("spurious_done", done, 0);
                else begin
                    me = sb.pop_front();
                    chk({me.tag, "_hi"}, hi, me.hi);
                    chk({me.tag, "_lo"}, lo, me.lo);
                    chk({me.tag, "_dz"}, div_zero, me.dz);
                    chk({me.tag, "_lat"}, cyc - me.c0, me.lat);
                    chk({me.tag, "_busy"}, busy, 0);
                end
            end else if (div_zero) chk("dz_without_done", div_zero, 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b0;
        @(negedge clk);

        drive(3'b000, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, "mult");
        start = 1'b0;
        chk("busy_calc", busy, 1);
        drain();
        drive(3'b001, 32'hFFFF_FFFD, 32'd7, 1, 32'h0000_0006, 32'hFFFF_FFEB, 0, "multu");
        start = 1'b0; drain();

`ifdef MDU_DIV_EN
        drive(3'b010, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg");
        start = 1'b0; drain();
        drive(3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, "divu");
        start = 1'b0; drain();
        drive(3'b011, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF, 1, "divu_zero");
        start = 1'b0; drain();
        drive(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 0, "div_ovf");
        start = 1'b0; drain();
        // Start while busy must be dropped without disturbing the running DIVU.
        drive(3'b011, 32'd1000, 32'd9, 1, 32'd1, 32'd111, 0, "divu_busy");
        start = 1'b0;
        repeat (4) @(negedge clk);
        drive(3'b001, 32'd2, 32'd3, 0, '0, '0, 0, "");
        start = 1'b0; drain();
        repeat (3) @(negedge clk);
        chk("ignored_hi", hi, 32'd1);
        chk("ignored_lo", lo, 32'd111);
`else
        drive(3'b010, 32'd100, 32'd7, 0, '0, '0, 0, "");
        start = 1'b0;
        chk("nodiv_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("nodiv_busy_late", busy, 0);
        chk("nodiv_hi", hi, curHi);
        chk("nodiv_lo", lo, curLo);
`endif

        drive(3'b100, 32'hCAFE_F00D, 32'd0, 1, 32'hCAFE_F00D, curLo, 0, "mthi");
        chk("mthi_busy", busy, 0);
        drive(3'b101, 32'h1234_5678, 32'd0, 1, curHi, 32'h1234_5678, 0, "mtlo");
        chk("mtlo_busy", busy, 0);
        start = 1'b0; drain();
        repeat (3) @(negedge clk);
        chk("mt_hold_hi", hi, 32'hCAFE_F00D);
        chk("mt_hold_lo", lo, 32'h1234_5678);

        drive(3'b110, 32'hDEAD_BEEF, 32'd5, 0, '0, '0, 0, "");
        start = 1'b0;
        chk("rsvd_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("rsvd_hi", hi, curHi);
        chk("rsvd_lo", lo, curLo);

        // Reset during CALC discards the multiply entirely.
        drive(3'b000, 32'h0001_0003, 32'h0000_0105, 0, '0, '0, 0, "");
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        rst = 1'b0;
        curHi = '0; curLo = '0;
        repeat (40) @(negedge clk);
        chk("midrst_busy_late", busy, 0);

        for (int i = 0; i < 24; i++) begin
`ifdef MDU_DIV_EN
            rOp = 3'($urandom_range(0, 3));
`else
            rOp = 3'($urandom_range(0, 1));
`endif
            rA = $urandom;
            rB = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            m  = model(rOp, rA, rB);
            drive(rOp, rA, rB, 1, m[63:32], m[31:0], m[64], "rand");
            start = 1'b0;
            drain();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
